// File: rtl/data_16x4_tx_module_pkg.sv
// Shared definitions for the 16x4 readout path: state encodings, opcodes and byte-lane select.
package data_16x4_tx_module_pkg;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_SEND      = 2'd1;
   localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
   localparam logic [1:0] ST_WAIT_DONE = 2'd3;

   localparam logic [7:0] DATA_WRITE_ADDR = 8'h02;
   localparam logic [7:0] DATA_READ_ADDR  = 8'h03;

   localparam logic [3:0] LAST_IDX = 4'd8;

   // Lane 0 is the header; lanes 1..8 walk the words low byte first.
   function automatic logic [7:0] byte_lane(input logic [3:0]  idx,
                                            input logic [7:0]  hdr,
                                            input logic [15:0] w0,
                                            input logic [15:0] w1,
                                            input logic [15:0] w2,
                                            input logic [15:0] w3);
      logic [7:0] b;
      case (idx)
         4'd0:    b = hdr;
         4'd1:    b = w0[7:0];
         4'd2:    b = w0[15:8];
         4'd3:    b = w1[7:0];
         4'd4:    b = w1[15:8];
         4'd5:    b = w2[7:0];
         4'd6:    b = w2[15:8];
         4'd7:    b = w3[7:0];
         4'd8:    b = w3[15:8];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/uart_rise_detect.sv
// Turns the level RX strobe into a one-cycle enable on its rising edge.
module uart_rise_detect (
   input  logic Clock,
   input  logic rst,
   input  logic uart_rw,
   output logic uart_en
);

   logic uart_rw_q;

   always_ff @(posedge Clock) begin
      if (rst) begin
         uart_rw_q <= 1'b0;
      end else begin
         uart_rw_q <= uart_rw;
      end
   end

   assign uart_en = uart_rw & ~uart_rw_q;

endmodule

// File: rtl/data_16x4_tx_module.sv
// Readout engine: on a read command, snapshots four words and streams them byte-wise to a UART TX.
module data_16x4_tx_module
   import data_16x4_tx_module_pkg::*;
#(
   parameter logic [7:0]  DATA_READ_ADDR = data_16x4_tx_module_pkg::DATA_READ_ADDR,
   parameter bit          ECHO_HEADER    = 1'b1,
   parameter int unsigned ACK_TIMEOUT    = 4
) (
   input  logic        Clock,
   input  logic        rst,
   input  logic        uart_rw,
   input  logic [7:0]  uart_in,
   input  logic [15:0] data0,
   input  logic [15:0] data1,
   input  logic [15:0] data2,
   input  logic [15:0] data3,
   input  logic        tx_busy,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   output logic        busy,
   output logic        done
);

   localparam logic [7:0] TIMER_LAST = 8'(ACK_TIMEOUT - 1);

   logic        uart_en;
   logic [1:0]  state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [7:0]  timer_q, timer_d;
   logic [15:0] sh_q [4];
   logic [15:0] sh_d [4];
   logic        tx_start_q, tx_start_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   uart_rise_detect u_rise (
      .Clock   (Clock),
      .rst     (rst),
      .uart_rw (uart_rw),
      .uart_en (uart_en)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      timer_d    = timer_q;
      sh_d       = sh_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (uart_en && (uart_in == DATA_READ_ADDR)) begin
               sh_d[0] = data0;
               sh_d[1] = data1;
               sh_d[2] = data2;
               sh_d[3] = data3;
               idx_d   = ECHO_HEADER ? 4'd0 : 4'd1;
               busy_d  = 1'b1;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (!tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = byte_lane(idx_q, DATA_READ_ADDR, sh_q[0], sh_q[1], sh_q[2], sh_q[3]);
               timer_d    = 8'd0;
               state_d    = ST_WAIT_BUSY;
            end
         end
         ST_WAIT_BUSY: begin
            // A TX that never acknowledges is assumed done once the window expires.
            if (tx_busy || (timer_q == TIMER_LAST)) begin
               state_d = ST_WAIT_DONE;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               if (idx_q == LAST_IDX) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = ST_SEND;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= 4'd0;
         timer_q    <= 8'd0;
         sh_q       <= '{default: 16'h0000};
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         timer_q    <= timer_d;
         sh_q       <= sh_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule
